// File: rtl/mse_frame_tx_if.sv
// Purpose : bundles the collector-side capture strobe/data and the UART-side byte strobe
//           plus status for mse_frame_tx.
// Ports   : master = collector/bench side (drives mse_valid, mse_data, clr_ovr),
//           slave  = framer side (drives com_txvalid, com_txdata, busy, overrun).
interface mse_frame_tx_if #(
    parameter int NUM_CH  = 2,
    parameter int DATA_WL = 64
);
    logic                        mse_valid;
    logic [NUM_CH*DATA_WL-1:0]   mse_data;
    logic                        clr_ovr;
    logic                        com_txvalid;
    logic [7:0]                  com_txdata;
    logic                        busy;
    logic                        overrun;

    modport master (
        output mse_valid, mse_data, clr_ovr,
        input  com_txvalid, com_txdata, busy, overrun
    );

    modport slave (
        input  mse_valid, mse_data, clr_ovr,
        output com_txvalid, com_txdata, busy, overrun
    );
endinterface

// File: rtl/mse_frame_tx.sv
// Purpose : captures NUM_CH MSE words and serialises HEADER, SEQ, data (MSB first), XOR CHK.
// Latency : HEADER strobe in the cycle after mse_valid; later bytes every BYTE_GAP cycles.
// Backpres: none downstream (UART has no ready); mse_valid while busy is dropped and flags overrun.
//
// Ports: clk, rstn (async active-low); bus (slave modport): mse_valid/mse_data/clr_ovr in,
//        com_txvalid/com_txdata/busy/overrun out, all outputs registered.
module mse_frame_tx #(
    parameter int          NUM_CH   = 2,
    parameter int          DATA_WL  = 64,
    parameter int          BYTE_GAP = 8700,
    parameter logic [7:0]  HEADER   = 8'hA5
) (
    input  logic          clk,
    input  logic          rstn,
    mse_frame_tx_if.slave bus
);
    localparam int BPC   = DATA_WL / 8;
    localparam int NB    = NUM_CH * BPC;
    localparam int L     = NB + 3;
    localparam int IDX_W = $clog2(L);
    localparam int GAP_W = (BYTE_GAP > 2) ? $clog2(BYTE_GAP - 1) : 1;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(L - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(BYTE_GAP - 2);

    typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

    state_t                    state, state_nxt;
    logic [IDX_W-1:0]          idx, idx_nxt;     // index of the byte most recently strobed
    logic [GAP_W-1:0]          gap_cnt, gap_nxt;
    logic [NUM_CH*DATA_WL-1:0] shadow;
    logic [7:0]                seq;
    logic [7:0]                chk;
    logic [7:0]                byte_nxt;
    logic                      strobe;
    logic                      txvalid_q;
    logic [7:0]                txdata_q;
    logic                      busy_q;
    logic                      overrun_q;

    assign bus.com_txvalid = txvalid_q;
    assign bus.com_txdata  = txdata_q;
    assign bus.busy        = busy_q;
    assign bus.overrun     = overrun_q;

    // The state names the cycle being presented on the outputs: the strobe register is
    // loaded on the edge that enters SEND, so capture and HEADER share one edge.
    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        gap_nxt   = gap_cnt;
        strobe    = 1'b0;
        unique case (state)
            IDLE: begin
                if (bus.mse_valid) begin
                    state_nxt = SEND;
                    idx_nxt   = '0;
                    strobe    = 1'b1;
                end
            end
            SEND: begin
                state_nxt = GAP;
                gap_nxt   = '0;
            end
            GAP: begin
                if (gap_cnt == GAP_LAST) begin
                    if (idx == LAST_IDX) begin
                        state_nxt = IDLE;
                    end else begin
                        state_nxt = SEND;
                        idx_nxt   = idx + 1'b1;
                        strobe    = 1'b1;
                    end
                end else begin
                    gap_nxt = gap_cnt + 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase

        // Byte for idx_nxt. HEADER needs no shadow, so it can leave on the capture edge.
        byte_nxt = 8'h00;
        if (idx_nxt == '0) begin
            byte_nxt = HEADER;
        end else if (idx_nxt == IDX_W'(1)) begin
            byte_nxt = seq;
        end else if (idx_nxt == LAST_IDX) begin
            byte_nxt = chk;
        end else begin
            for (int j = 0; j < NB; j++) begin
                if (idx_nxt == IDX_W'(j + 2))
                    byte_nxt = shadow[(j / BPC) * DATA_WL + (BPC - 1 - (j % BPC)) * 8 +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= IDLE;
            idx       <= '0;
            gap_cnt   <= '0;
            shadow    <= '0;
            seq       <= 8'h00;
            chk       <= 8'h00;
            txvalid_q <= 1'b0;
            txdata_q  <= 8'h00;
            busy_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state     <= state_nxt;
            idx       <= idx_nxt;
            gap_cnt   <= gap_nxt;
            txvalid_q <= strobe;
            busy_q    <= (state_nxt != IDLE);
            if (strobe)
                txdata_q <= byte_nxt;

            if (state == IDLE && bus.mse_valid) begin
                shadow <= bus.mse_data;
                chk    <= 8'h00;
            end else if (strobe) begin
                if (idx_nxt == LAST_IDX) begin
                    chk <= 8'h00;
                    seq <= seq + 8'd1;
                end else begin
                    chk <= chk ^ byte_nxt;
                end
            end

            // A dropped capture outranks a same-cycle clear.
            if (bus.mse_valid && state != IDLE)
                overrun_q <= 1'b1;
            else if (bus.clr_ovr)
                overrun_q <= 1'b0;
        end
    end
endmodule
